// File: rtl/sdram_write_sequencer.sv
// rtl/sdram_write_sequencer.sv - burst word writer from a valid/ready stream into an Avalon SDRAM socket
//
// Purpose: Takes a start command (base address, word count) and a stream of words.
//          It issues one Avalon write per word at consecutive word addresses and
//          honours waitrequest. It pulses sdram_finished when the transfer ends.
// Ports:
//   clock50MHz, reset              clock, asynchronous active-low reset
//   start, base_address,
//   word_count                     transfer command, sampled in IDLE
//   abort                          early termination, sampled in LOAD/WRITE
//   in_valid, in_data, in_ready    input word stream
//   sdram_address, sdram_write,
//   sdram_writedata,
//   sdram_waitrequest              Avalon write master towards the socket
//   sdram_finished                 one-cycle completion pulse
//   busy, words_written            status
module sdram_write_sequencer #(
  parameter int DATAWIDTH      = 32,
  parameter int ADDRESSWIDTH   = 32,
  parameter int COUNTWIDTH     = 16,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic                    clock50MHz,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDRESSWIDTH-1:0] base_address,
  input  logic [COUNTWIDTH-1:0]   word_count,
  input  logic                    abort,
  input  logic                    in_valid,
  input  logic [DATAWIDTH-1:0]    in_data,
  output logic                    in_ready,
  output logic [ADDRESSWIDTH-1:0] sdram_address,
  output logic                    sdram_write,
  output logic [DATAWIDTH-1:0]    sdram_writedata,
  input  logic                    sdram_waitrequest,
  output logic                    sdram_finished,
  output logic                    busy,
  output logic [COUNTWIDTH-1:0]   words_written
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [COUNTWIDTH-1:0] remaining;
  logic                  abort_pending;
  logic                  take_word;
  logic                  write_accept;

  always_ff @(posedge clock50MHz or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    take_word    = 1'b0;
    write_accept = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = (word_count == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        // abort wins over a word offered in the same cycle
        if (abort) begin
          next_state = S_DONE;
        end else if (in_valid) begin
          take_word  = 1'b1;
          next_state = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!sdram_waitrequest) begin
          write_accept = 1'b1;
          // abort on the accepting edge itself counts as pending too
          if (remaining == COUNTWIDTH'(1) || abort_pending || abort) begin
            next_state = S_DONE;
          end else begin
            next_state = S_LOAD;
          end
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  assign in_ready = (state == S_LOAD);

  always_ff @(posedge clock50MHz or negedge reset) begin
    if (!reset) begin
      sdram_address   <= '0;
      sdram_writedata <= '0;
      sdram_write     <= 1'b0;
      sdram_finished  <= 1'b0;
      busy            <= 1'b0;
      words_written   <= '0;
      remaining       <= '0;
      abort_pending   <= 1'b0;
    end else begin
      // status outputs are registered copies of the state being entered
      busy           <= (next_state != S_IDLE);
      sdram_finished <= (next_state == S_DONE);

      if (state == S_IDLE && start) begin
        sdram_address <= base_address;
        remaining     <= word_count;
        words_written <= '0;
        abort_pending <= 1'b0;
      end

      if (take_word) begin
        sdram_writedata <= in_data;
        sdram_write     <= 1'b1;
      end

      // an abort during WRITE never retracts the write in flight
      if (state == S_WRITE && abort) begin
        abort_pending <= 1'b1;
      end

      if (write_accept) begin
        sdram_write   <= 1'b0;
        sdram_address <= sdram_address + ADDRESSWIDTH'(BYTES_PER_WORD);
        remaining     <= remaining - COUNTWIDTH'(1);
        words_written <= words_written + COUNTWIDTH'(1);
      end

      if (state == S_DONE) begin
        abort_pending <= 1'b0;
      end
    end
  end

endmodule
